laser_controller: RTL

Owns the player's single laser projectile. It turns the fire button into at most one in-flight shot and advances the shot once per video frame. It retires the shot on an invader hit or on reaching the top limit, then enforces a cooldown before the next shot. It sits directly upstream of vga_controller: it drives that block's laser_active/laser_x/laser_y inputs, and it consumes that block's frame and invader_collision outputs.

---
 rtl/laser_controller.sv | 128 ++++++++++++
 1 files changed

// File: rtl/laser_controller.sv
// Player laser projectile: fire-button conditioning, once-per-frame flight,
// collision/top-limit retirement and post-shot cooldown.
module laser_controller #(
  parameter int TOP_LIMIT       = 8,
  parameter int PROJ_SPEED      = 4,
  parameter int PLAYER_W        = 26,
  parameter int PROJ_W          = 2,
  parameter int PROJ_H          = 8,
  parameter int COOLDOWN_FRAMES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame,
  input  logic       fire_btn,
  input  logic [9:0] player_x,
  input  logic [9:0] player_y,
  input  logic [5:0] invader_collision,
  output logic       laser_active,
  output logic [9:0] laser_x,
  output logic [9:0] laser_y,
  output logic       hit,
  output logic [5:0] hit_mask
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] FLY      = 2'd1;
  localparam logic [1:0] COOLDOWN = 2'd2;

  localparam int CW = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

  localparam logic [9:0] SPAWN_MIN = 10'(TOP_LIMIT + PROJ_H);
  localparam logic [9:0] RETIRE_Y  = 10'(TOP_LIMIT + PROJ_SPEED);
  localparam logic [9:0] X_OFFSET  = 10'((PLAYER_W - PROJ_W) / 2);

  logic [1:0]    state;
  logic [CW-1:0] cd_cnt;
  logic          sync1, sync2, sync3;
  logic          armed;
  logic          fire_req;
  logic [5:0]    coll_latch;
  logic          rise;

  assign rise = sync2 & ~sync3;

  // sync3 is the edge detector's history flop; armed blocks auto-repeat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      sync3    <= 1'b0;
      armed    <= 1'b1;
      fire_req <= 1'b0;
    end else begin
      sync1 <= fire_btn;
      sync2 <= sync1;
      sync3 <= sync2;
      if (rise && armed)
        armed <= 1'b0;
      else if (!sync2)
        armed <= 1'b1;
      if (state != IDLE)
        fire_req <= 1'b0;
      else if (rise && armed)
        fire_req <= 1'b1;
      else if (frame)
        fire_req <= 1'b0;
    end
  end

  // Latch is sampled by the FSM on the frame cycle and cleared in that same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      coll_latch <= '0;
    else if (frame)
      coll_latch <= '0;
    else if (laser_active)
      coll_latch <= coll_latch | invader_collision;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      laser_active <= 1'b0;
      laser_x      <= '0;
      laser_y      <= '0;
      hit          <= 1'b0;
      hit_mask     <= '0;
      cd_cnt       <= '0;
    end else begin
      hit <= 1'b0;
      if (frame) begin
        case (state)
          IDLE: begin
            if (fire_req && player_y >= SPAWN_MIN) begin
              laser_x      <= player_x + X_OFFSET;
              laser_y      <= player_y - 10'(PROJ_H);
              laser_active <= 1'b1;
              state        <= FLY;
            end
          end
          FLY: begin
            if (coll_latch != '0) begin
              hit          <= 1'b1;
              hit_mask     <= coll_latch;
              laser_active <= 1'b0;
              cd_cnt       <= CW'(COOLDOWN_FRAMES);
              state        <= COOLDOWN;
            end else if (laser_y < RETIRE_Y) begin
              laser_active <= 1'b0;
              cd_cnt       <= CW'(COOLDOWN_FRAMES);
              state        <= COOLDOWN;
            end else begin
              laser_y <= laser_y - 10'(PROJ_SPEED);
            end
          end
          COOLDOWN: begin
            if (cd_cnt == '0)
              state <= IDLE;
            else
              cd_cnt <= cd_cnt - 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
